// File: rtl/puf_pkg.sv
// puf_pkg -- shared state encoding, default parameters and width helpers for the PUF race launcher.
// Revision 1.0
`default_nettype none

package puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        RACE    = 3'd2,
        RECOVER = 3'd3,
        DONE    = 3'd4
    } puf_state_t;

    localparam int DEF_N_STAGES       = 64;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_RACE_CYCLES    = 8;
    localparam int DEF_RECOVER_CYCLES = 4;
    localparam int DEF_VOTES          = 5;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff -- 1-bit two-flop synchronizer with asynchronous active-low reset to 0.
// Revision 1.0
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/puf_race_launcher.sv
// puf_race_launcher -- loads a challenge, launches VOTES races into the arbiter-PUF chain, majority-votes the result.
// Revision 1.0
`default_nettype none

module puf_race_launcher
    import puf_pkg::*;
#(
    parameter int N_STAGES       = DEF_N_STAGES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int RACE_CYCLES    = DEF_RACE_CYCLES,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int VOTES          = DEF_VOTES
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Req_valid,
    output logic                         Req_ready,
    input  logic [N_STAGES-1:0]          Req_challenge,
    output logic [N_STAGES-1:0]          Challenge,
    output logic                         Race_start,
    input  logic                         Arbiter_out,
    output logic                         Resp_valid,
    input  logic                         Resp_ready,
    output logic                         Resp_bit,
    output logic [$clog2(VOTES+1)-1:0]   Resp_confidence
);

    localparam int VW = $clog2(VOTES + 1);
    localparam int PW = cnt_width(max3(SETTLE_CYCLES, RACE_CYCLES, RECOVER_CYCLES));

    localparam logic [PW-1:0] SETTLE_LAST  = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] RACE_LAST    = PW'(RACE_CYCLES - 1);
    localparam logic [PW-1:0] RECOVER_LAST = PW'(RECOVER_CYCLES - 1);
    localparam logic [VW-1:0] VOTES_C      = VW'(VOTES);
    localparam logic [VW-1:0] HALF_VOTES   = VW'(VOTES / 2);

    puf_state_t             state, state_n;
    logic [PW-1:0]          phase, phase_n;
    logic [VW-1:0]          votes, votes_n;
    logic [VW-1:0]          ones, ones_n;
    logic [N_STAGES-1:0]    challenge_n;
    logic                   race_n;
    logic                   resp_valid_n;
    logic                   resp_bit_n;
    logic [VW-1:0]          resp_conf_n;
    logic                   arb_sync;

    sync_2ff u_arb_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Arbiter_out),
        .q     (arb_sync)
    );

    assign Req_ready = (state == IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state           <= IDLE;
            phase           <= '0;
            votes           <= '0;
            ones            <= '0;
            Challenge       <= '0;
            Race_start      <= 1'b0;
            Resp_valid      <= 1'b0;
            Resp_bit        <= 1'b0;
            Resp_confidence <= '0;
        end else begin
            state           <= state_n;
            phase           <= phase_n;
            votes           <= votes_n;
            ones            <= ones_n;
            Challenge       <= challenge_n;
            Race_start      <= race_n;
            Resp_valid      <= resp_valid_n;
            Resp_bit        <= resp_bit_n;
            Resp_confidence <= resp_conf_n;
        end
    end

    // Race_start is computed alongside the next state so it is high exactly while in RACE.
    always_comb begin
        state_n      = state;
        phase_n      = phase;
        votes_n      = votes;
        ones_n       = ones;
        challenge_n  = Challenge;
        race_n       = Race_start;
        resp_valid_n = Resp_valid;
        resp_bit_n   = Resp_bit;
        resp_conf_n  = Resp_confidence;

        case (state)
            IDLE: begin
                if (Req_valid) begin
                    challenge_n = Req_challenge;
                    votes_n     = '0;
                    ones_n      = '0;
                    phase_n     = '0;
                    state_n     = SETTLE;
                end
            end
            SETTLE: begin
                if (phase == SETTLE_LAST) begin
                    phase_n = '0;
                    race_n  = 1'b1;
                    state_n = RACE;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            RACE: begin
                if (phase == RACE_LAST) begin
                    phase_n = '0;
                    race_n  = 1'b0;
                    votes_n = votes + 1'b1;
                    ones_n  = ones + VW'(arb_sync);
                    state_n = RECOVER;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            RECOVER: begin
                if (phase == RECOVER_LAST) begin
                    phase_n = '0;
                    if (votes < VOTES_C) begin
                        race_n  = 1'b1;
                        state_n = RACE;
                    end else begin
                        resp_valid_n = 1'b1;
                        resp_bit_n   = (ones > HALF_VOTES);
                        resp_conf_n  = ones;
                        state_n      = DONE;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            DONE: begin
                if (Resp_ready) begin
                    resp_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                race_n  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_puf_race_launcher.sv
// tb_puf_race_launcher -- directed self-checking bench for the default and a short-parameter launcher.
`default_nettype none

module tb_puf_race_launcher;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_challenge;
    logic [63:0] challenge;
    logic        race_start;
    logic        arb;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_bit;
    logic [2:0]  resp_conf;

    logic        v_req_valid;
    logic        v_req_ready;
    logic [63:0] v_req_challenge;
    logic [63:0] v_challenge;
    logic        v_race_start;
    logic        v_arb;
    logic        v_resp_valid;
    logic        v_resp_ready;
    logic        v_resp_bit;
    logic [0:0]  v_resp_conf;

    int vecs;
    int errs;

    puf_race_launcher dut (
        .Clk             (clk),
        .Rst_n           (rst_n),
        .Req_valid       (req_valid),
        .Req_ready       (req_ready),
        .Req_challenge   (req_challenge),
        .Challenge       (challenge),
        .Race_start      (race_start),
        .Arbiter_out     (arb),
        .Resp_valid      (resp_valid),
        .Resp_ready      (resp_ready),
        .Resp_bit        (resp_bit),
        .Resp_confidence (resp_conf)
    );

    puf_race_launcher #(
        .VOTES          (1),
        .SETTLE_CYCLES  (1),
        .RACE_CYCLES    (3),
        .RECOVER_CYCLES (1)
    ) dut_v (
        .Clk             (clk),
        .Rst_n           (rst_n),
        .Req_valid       (v_req_valid),
        .Req_ready       (v_req_ready),
        .Req_challenge   (v_req_challenge),
        .Challenge       (v_challenge),
        .Race_start      (v_race_start),
        .Arbiter_out     (v_arb),
        .Resp_valid      (v_resp_valid),
        .Resp_ready      (v_resp_ready),
        .Resp_bit        (v_resp_bit),
        .Resp_confidence (v_resp_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] chal);
        req_challenge = chal;
        req_valid     = 1'b1;
        step();
        req_valid     = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    // Runs one request to Resp_valid, applying pat[k] to the arbiter for race k and profiling Race_start.
    task automatic wait_resp(input logic [4:0] pat, input logic [63:0] exp_chal, input bit toggle,
                             output int lat, output int pulses, output int pulse_bad,
                             output int first_rise, output int chal_bad);
        int  hi;
        int  lo;
        logic prev;
        lat = 0; pulses = 0; pulse_bad = 0; first_rise = -1; chal_bad = 0;
        hi = 0; lo = 0; prev = race_start;
        arb = pat[0];
        while (!resp_valid && lat < 200) begin
            if (toggle) req_challenge = ~req_challenge;
            step();
            lat++;
            if (challenge !== exp_chal) chal_bad++;
            if (race_start && !prev) begin
                if (first_rise < 0) first_rise = lat;
                if (pulses > 0 && lo != 4) pulse_bad++;
                hi = 0;
            end
            if (!race_start && prev) begin
                pulses++;
                if (hi != 8) pulse_bad++;
                lo = 0;
                if (pulses < 5) arb = pat[pulses];
            end
            if (race_start) hi++; else lo++;
            prev = race_start;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
        vecs++; if (challenge !== 64'h0) begin errs++; $display("FAIL reset_challenge: got %0h expected 0", challenge); end
        vecs++; if (race_start !== 1'b0) begin errs++; $display("FAIL reset_race_start: got %0b expected 0", race_start); end
        vecs++; if (resp_valid !== 1'b0 || resp_bit !== 1'b0 || resp_conf !== 3'd0)
            begin errs++; $display("FAIL reset_resp: got v=%0b b=%0b c=%0d expected 0 0 0", resp_valid, resp_bit, resp_conf); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_all_ones();
        int lat, pulses, pbad, first, cbad;
        accept(64'hDEADBEEF_01234567);
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL busy_req_ready: got %0b expected 0", req_ready); end
        wait_resp(5'b11111, 64'hDEADBEEF_01234567, 1'b0, lat, pulses, pbad, first, cbad);
        vecs++; if (lat != 64) begin errs++; $display("FAIL ones_latency: got %0d expected 64", lat); end
        vecs++; if (pulses != 5) begin errs++; $display("FAIL ones_pulses: got %0d expected 5", pulses); end
        vecs++; if (pbad != 0) begin errs++; $display("FAIL ones_pulse_shape: got %0d bad runs expected 0", pbad); end
        vecs++; if (first != 4) begin errs++; $display("FAIL ones_first_rise: got %0d expected 4", first); end
        vecs++; if (resp_bit !== 1'b1 || resp_conf !== 3'd5)
            begin errs++; $display("FAIL ones_resp: got b=%0b c=%0d expected 1 5", resp_bit, resp_conf); end
        handshake();
        vecs++; if (resp_valid !== 1'b0 || resp_bit !== 1'b1 || resp_conf !== 3'd5)
            begin errs++; $display("FAIL ones_after_hs: got v=%0b b=%0b c=%0d expected 0 1 5", resp_valid, resp_bit, resp_conf); end
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL ones_idle_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic test_votes();
        logic [4:0] pats [3];
        logic [2:0] exp_c [3];
        logic       exp_b [3];
        int lat, pulses, pbad, first, cbad;
        pats[0] = 5'b10101; exp_c[0] = 3'd3; exp_b[0] = 1'b1;
        pats[1] = 5'b01010; exp_c[1] = 3'd2; exp_b[1] = 1'b0;
        pats[2] = 5'b00000; exp_c[2] = 3'd0; exp_b[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            accept(64'h1111_0000_0000_0000 + 64'(i));
            wait_resp(pats[i], 64'h1111_0000_0000_0000 + 64'(i), 1'b0, lat, pulses, pbad, first, cbad);
            vecs++; if (resp_conf !== exp_c[i] || resp_bit !== exp_b[i])
                begin errs++; $display("FAIL votes_%0d: got c=%0d b=%0b expected c=%0d b=%0b", i, resp_conf, resp_bit, exp_c[i], exp_b[i]); end
            handshake();
            step();
        end
    endtask

    task automatic test_challenge_stability();
        int lat, pulses, pbad, first, cbad;
        accept(64'hA5A5_5A5A_F0F0_0F0F);
        wait_resp(5'b11111, 64'hA5A5_5A5A_F0F0_0F0F, 1'b1, lat, pulses, pbad, first, cbad);
        vecs++; if (cbad != 0) begin errs++; $display("FAIL chal_stable: got %0d bad cycles expected 0", cbad); end
        vecs++; if (lat != 64) begin errs++; $display("FAIL chal_latency: got %0d expected 64", lat); end
        handshake();
        vecs++; if (challenge !== 64'hA5A5_5A5A_F0F0_0F0F)
            begin errs++; $display("FAIL chal_idle_hold: got %0h expected a5a55a5af0f00f0f", challenge); end
        step();
    endtask

    task automatic test_backpressure();
        int lat, pulses, pbad, first, cbad, sbad;
        arb = 1'b1;
        accept(64'h0000_0000_0000_00AA);
        wait_resp(5'b11111, 64'h0000_0000_0000_00AA, 1'b0, lat, pulses, pbad, first, cbad);
        req_challenge = 64'h0000_0000_0000_00BB;
        req_valid     = 1'b1;
        sbad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (resp_valid !== 1'b1 || resp_bit !== 1'b1 || resp_conf !== 3'd5 ||
                req_ready !== 1'b0 || challenge !== 64'hAA) sbad++;
        end
        vecs++; if (sbad != 0) begin errs++; $display("FAIL bp_stable: got %0d bad cycles expected 0", sbad); end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        vecs++; if (resp_valid !== 1'b0 || challenge !== 64'hAA || req_ready !== 1'b1)
            begin errs++; $display("FAIL bp_hs_cycle: got v=%0b chal=%0h rdy=%0b expected 0 aa 1", resp_valid, challenge, req_ready); end
        step();
        req_valid = 1'b0;
        vecs++; if (challenge !== 64'hBB || req_ready !== 1'b0)
            begin errs++; $display("FAIL bp_next_accept: got chal=%0h rdy=%0b expected bb 0", challenge, req_ready); end
        wait_resp(5'b11111, 64'h0000_0000_0000_00BB, 1'b0, lat, pulses, pbad, first, cbad);
        vecs++; if (lat != 64) begin errs++; $display("FAIL bp_latency: got %0d expected 64", lat); end
        handshake();
        step();
    endtask

    task automatic test_reset_mid();
        int lat, pulses, pbad, first, cbad;
        arb = 1'b1;
        accept(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 18; i++) step();
        vecs++; if (race_start !== 1'b1) begin errs++; $display("FAIL mid_in_race: got %0b expected 1", race_start); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (race_start !== 1'b0 || challenge !== 64'h0 || resp_valid !== 1'b0)
            begin errs++; $display("FAIL mid_async: got rs=%0b chal=%0h v=%0b expected 0 0 0", race_start, challenge, resp_valid); end
        step();
        rst_n = 1'b1;
        step();
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %0b expected 1", req_ready); end
        accept(64'hFEED_FACE_CAFE_BABE);
        wait_resp(5'b11111, 64'hFEED_FACE_CAFE_BABE, 1'b0, lat, pulses, pbad, first, cbad);
        vecs++; if (lat != 64 || resp_conf !== 3'd5)
            begin errs++; $display("FAIL mid_fresh: got lat=%0d c=%0d expected 64 5", lat, resp_conf); end
        handshake();
        step();
    endtask

    task automatic test_variant();
        int lat;
        v_arb           = 1'b1;
        v_req_challenge = 64'h5;
        v_req_valid     = 1'b1;
        step();
        v_req_valid = 1'b0;
        lat = 0;
        while (!v_resp_valid && lat < 50) begin
            step();
            lat++;
        end
        vecs++; if (lat != 5) begin errs++; $display("FAIL var_latency: got %0d expected 5", lat); end
        vecs++; if (v_resp_bit !== 1'b1 || v_resp_conf !== 1'b1)
            begin errs++; $display("FAIL var_resp: got b=%0b c=%0d expected 1 1", v_resp_bit, v_resp_conf); end
        v_resp_ready = 1'b1;
        step();
        v_resp_ready = 1'b0;
        vecs++; if (v_resp_valid !== 1'b0 || v_req_ready !== 1'b1)
            begin errs++; $display("FAIL var_hs: got v=%0b rdy=%0b expected 0 1", v_resp_valid, v_req_ready); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_challenge = '0; arb = 1'b0; resp_ready = 1'b0;
        v_req_valid = 1'b0; v_req_challenge = '0; v_arb = 1'b0; v_resp_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_votes();
        test_challenge_stability();
        test_backpressure();
        test_reset_mid();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
